// File: rtl/ili9163_pattern_src.sv
// Pixel source for the ILI9163 path: solid, colour bars, checkerboard or framebuffer
// patterns, streamed one pixel per data_req with a fixed two-stage fetch pipeline.
module ili9163_pattern_src #(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned HEIGHT      = 128,
    parameter int unsigned PIXEL_SIZE  = 16,
    parameter int unsigned CHECK_SHIFT = 4,
    localparam int unsigned RESOLUTION = WIDTH * HEIGHT,
    localparam int unsigned AW         = $clog2(RESOLUTION)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [PIXEL_SIZE-1:0] color,
    input  logic                  data_req,
    output logic [AW-1:0]         mem_addr,
    input  logic [PIXEL_SIZE-1:0] mem_data,
    output logic [PIXEL_SIZE-1:0] pixel_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_tick,
    output logic [7:0]            frame_count,
    output logic                  overrun
);

    localparam int unsigned XW     = $clog2(WIDTH);
    localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BAR_PX = WIDTH / 8;
    localparam int unsigned BW     = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_STREAM, ST_DONE} state_e;

    state_e                state_q, state_d;
    logic                  pf_q, pf_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BW-1:0]         sub_q, sub_d;
    logic [2:0]            bar_q, bar_d;
    logic [1:0]            gap_q, gap_d;
    logic [1:0]            mode_q, mode_d;
    logic [PIXEL_SIZE-1:0] color_q, color_d;
    logic                  cont_q, cont_d;
    logic [PIXEL_SIZE-1:0] p1_q, p1_d;
    logic                  sel1_q, sel1_d;
    logic [PIXEL_SIZE-1:0] pixel_q, pixel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick_q, tick_d;
    logic [7:0]            count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic                  accept_c;
    logic                  drop_c;
    logic [PIXEL_SIZE-1:0] pix_c;
    logic [15:0]           bar_rgb_c;
    logic [31:0]           xs_c, ys_c;
    logic                  chk_c;

    // Pattern value for the current (x, y) under the latched mode
    always_comb begin
        xs_c  = 32'(x_q) >> CHECK_SHIFT;
        ys_c  = 32'(y_q) >> CHECK_SHIFT;
        chk_c = ((xs_c ^ ys_c) & 32'd1) != 32'd0;
        case (bar_q)
            3'd0:    bar_rgb_c = 16'hFFFF;
            3'd1:    bar_rgb_c = 16'hFFE0;
            3'd2:    bar_rgb_c = 16'h07FF;
            3'd3:    bar_rgb_c = 16'h07E0;
            3'd4:    bar_rgb_c = 16'hF81F;
            3'd5:    bar_rgb_c = 16'hF800;
            3'd6:    bar_rgb_c = 16'h001F;
            default: bar_rgb_c = 16'h0000;
        endcase
        case (mode_q)
            2'd0:    pix_c = color_q;
            2'd1:    pix_c = PIXEL_SIZE'(bar_rgb_c);
            2'd2:    pix_c = chk_c ? '0 : color_q;
            default: pix_c = '0;
        endcase
    end

    assign accept_c = (state_q == ST_STREAM) && data_req && (gap_q == 2'd0);
    assign drop_c   = (state_q == ST_STREAM) && data_req && (gap_q != 2'd0);

    always_comb begin
        state_d   = state_q;
        pf_d      = pf_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        bar_d     = bar_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        color_d   = color_q;
        cont_d    = cont_q;
        p1_d      = p1_q;
        sel1_d    = sel1_q;
        pixel_d   = pixel_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        tick_d    = 1'b0;

        if (gap_q != 2'd0) gap_d = gap_q - 2'd1;
        if (drop_c) overrun_d = 1'b1;

        // Stage 1 holds the pattern value, stage 2 picks it or the memory word
        if (state_q == ST_PREFETCH || state_q == ST_STREAM) begin
            p1_d    = pix_c;
            sel1_d  = (mode_q == 2'd3);
            pixel_d = sel1_q ? mem_data : p1_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    color_d = color;
                    cont_d  = continuous;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    sub_d   = '0;
                    bar_d   = '0;
                    gap_d   = '0;
                    pf_d    = 1'b0;
                    state_d = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                if (pf_q) begin
                    pf_d    = 1'b0;
                    state_d = ST_STREAM;
                end else begin
                    pf_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept_c) begin
                    gap_d = 2'd2;
                    if (addr_q == AW'(RESOLUTION - 1)) begin
                        tick_d  = 1'b1;
                        count_d = count_q + 8'd1;
                        if (cont_q) begin
                            mode_d  = mode;
                            color_d = color;
                            cont_d  = continuous;
                            x_d     = '0;
                            y_d     = '0;
                            addr_d  = '0;
                            sub_d   = '0;
                            bar_d   = '0;
                            pf_d    = 1'b0;
                            state_d = ST_PREFETCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                        if (x_q == XW'(WIDTH - 1)) begin
                            x_d   = '0;
                            y_d   = y_q + YW'(1);
                            sub_d = '0;
                            bar_d = '0;
                        end else begin
                            x_d = x_q + XW'(1);
                            if (sub_q == BW'(BAR_PX - 1)) begin
                                sub_d = '0;
                                bar_d = bar_q + 3'd1;
                            end else begin
                                sub_d = sub_q + BW'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_PREFETCH) || (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pf_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            sub_q     <= '0;
            bar_q     <= '0;
            gap_q     <= '0;
            mode_q    <= '0;
            color_q   <= '0;
            cont_q    <= 1'b0;
            p1_q      <= '0;
            sel1_q    <= 1'b0;
            pixel_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pf_q      <= pf_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            sub_q     <= sub_d;
            bar_q     <= bar_d;
            gap_q     <= gap_d;
            mode_q    <= mode_d;
            color_q   <= color_d;
            cont_q    <= cont_d;
            p1_q      <= p1_d;
            sel1_q    <= sel1_d;
            pixel_q   <= pixel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem_addr    = addr_q;
    assign pixel_out   = pixel_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_tick  = tick_q;
    assign frame_count = count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ili9163_pattern_src.sv
// Scoreboard bench for ili9163_pattern_src on a 16x4 frame with 2-pixel checker squares.
module tb_ili9163_pattern_src;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 4;
    localparam int unsigned N  = W * H;
    localparam int unsigned CS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] color = 16'h0;
    logic        data_req = 1'b0;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] pixel_out;
    logic        busy, frame_done, frame_tick, overrun;
    logic [7:0]  frame_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    ili9163_pattern_src #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(16), .CHECK_SHIFT(CS)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
        .color(color), .data_req(data_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_out(pixel_out), .busy(busy), .frame_done(frame_done),
        .frame_tick(frame_tick), .frame_count(frame_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Framebuffer with one clock of read latency
    always @(posedge clk) mem_data <= 16'(32'h100 + 32'(mem_addr));

    function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] c, input int n);
        int x, y;
        x = n % W;
        y = n / W;
        case (m)
            2'd0: return c;
            2'd1: begin
                case (x / (W / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 16'h0000 : c;
            default: return 16'(32'h100 + n);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; data_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] c, input logic cont);
        mode = m; color = c; continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL start_done got %b want 0", frame_done); end
        exp_q.push_back(model(m, c, 0));
        if (!cont) begin
            mode = m ^ 2'd1;
            color = ~c;
        end
        tick(); tick();
    endtask

    task automatic run_pixels(input logic [1:0] m, input logic [15:0] c, input logic cont,
                              input int exp_count, input int sw_at, input logic [1:0] sw_mode,
                              input logic st_last);
        logic [15:0] e;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL scoreboard_empty at pixel %0d", i);
            end else begin
                e = exp_q.pop_front();
                if (pixel_out !== e) begin
                    errors++; $display("FAIL pixel[%0d] mode %0d got %h want %h", i, m, pixel_out, e);
                end
            end
            if (cont) begin
                checks++;
                if (frame_done !== 1'b0) begin errors++; $display("FAIL cont_done px %0d got %b want 0", i, frame_done); end
            end
            if (i == sw_at) mode = sw_mode;
            if (i < N - 1) exp_q.push_back(model(m, c, i + 1));
            else if (cont) exp_q.push_back(model(mode, color, 0));
            data_req = 1'b1;
            start = st_last && (i == N - 1);
            tick();
            data_req = 1'b0;
            start = 1'b0;
            if (i == N - 1) begin
                checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_high got %b want 1", frame_tick); end
                checks++; if (frame_count !== 8'(exp_count)) begin errors++; $display("FAIL frame_count got %0d want %0d", frame_count, exp_count); end
                checks++; if (frame_done !== !cont) begin errors++; $display("FAIL end_done got %b want %b", frame_done, !cont); end
                checks++; if (busy !== cont) begin errors++; $display("FAIL end_busy got %b want %b", busy, cont); end
            end
            tick();
            if (i == N - 1) begin
                checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", frame_tick); end
            end
            tick(); tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if ({busy, frame_done, frame_tick, overrun} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, frame_done, frame_tick, overrun}); end
        checks++; if (pixel_out !== 16'h0 || mem_addr !== 6'd0 || frame_count !== 8'd0) begin errors++; $display("FAIL reset_values got %h/%0d/%0d want 0/0/0", pixel_out, mem_addr, frame_count); end
        rst = 1'b1;
        tick();
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        checks++; if (overrun !== 1'b0 || busy !== 1'b0 || mem_addr !== 6'd0) begin errors++; $display("FAIL idle_req got ovr=%b busy=%b addr=%0d want 0/0/0", overrun, busy, mem_addr); end
    endtask

    task automatic test_solid();
        do_reset();
        do_start(2'd0, 16'h07FF, 1'b0);
        run_pixels(2'd0, 16'h07FF, 1'b0, 1, -1, 2'd0, 1'b0);
    endtask

    task automatic test_bars();
        do_start(2'd1, 16'h1234, 1'b0);
        run_pixels(2'd1, 16'h1234, 1'b0, 2, -1, 2'd0, 1'b0);
    endtask

    task automatic test_checker();
        do_reset();
        do_start(2'd2, 16'hF800, 1'b0);
        run_pixels(2'd2, 16'hF800, 1'b0, 1, -1, 2'd0, 1'b0);
    endtask

    task automatic test_framebuffer();
        do_reset();
        do_start(2'd3, 16'h0, 1'b0);
        run_pixels(2'd3, 16'h0, 1'b0, 1, -1, 2'd0, 1'b1);
        checks++; if (mem_addr !== 6'd63) begin errors++; $display("FAIL fb_last_addr got %0d want 63", mem_addr); end
    endtask

    task automatic test_continuous();
        do_reset();
        do_start(2'd0, 16'h1234, 1'b1);
        run_pixels(2'd0, 16'h1234, 1'b1, 1, 10, 2'd1, 1'b0);
        continuous = 1'b0;
        run_pixels(2'd1, 16'h1234, 1'b1, 2, -1, 2'd0, 1'b0);
        run_pixels(2'd1, 16'h1234, 1'b0, 3, -1, 2'd0, 1'b0);
    endtask

    task automatic test_overrun_reset();
        do_reset();
        do_start(2'd3, 16'h0, 1'b0);
        exp_q.delete();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b want 0", overrun); end
        data_req = 1'b1; tick();
        data_req = 1'b0; tick();
        data_req = 1'b1; tick();
        data_req = 1'b0;
        checks++; if (mem_addr !== 6'd1) begin errors++; $display("FAIL ovr_addr got %0d want 1", mem_addr); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        tick(); tick();
        data_req = 1'b1; tick();
        data_req = 1'b0;
        checks++; if (mem_addr !== 6'd2 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_after got addr=%0d ovr=%b want 2/1", mem_addr, overrun); end
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, frame_done, frame_tick, overrun} !== 4'b0) begin errors++; $display("FAIL midrst_flags got %b want 0000", {busy, frame_done, frame_tick, overrun}); end
        checks++; if (pixel_out !== 16'h0 || mem_addr !== 6'd0 || frame_count !== 8'd0) begin errors++; $display("FAIL midrst_values got %h/%0d/%0d want 0/0/0", pixel_out, mem_addr, frame_count); end
        tick();
        rst = 1'b1;
        tick();
        data_req = 1'b1; tick();
        data_req = 1'b0; tick(); tick();
        checks++; if (busy !== 1'b0 || mem_addr !== 6'd0 || overrun !== 1'b0) begin errors++; $display("FAIL post_rst_idle got busy=%b addr=%0d ovr=%b want 0/0/0", busy, mem_addr, overrun); end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_checker();
        test_framebuffer();
        test_continuous();
        test_overrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ili9163_pattern_src.md
# ili9163_pattern_src

Parametrised pixel source for the ILI9163 display path, sitting between the frame/pattern logic and `ili9163_controller`. It replaces the fixed single-colour, single-shot pixel loop with several selectable modes:
- solid colour, 8-bar colour bars, checkerboard, or external framebuffer read;
- single-shot or continuous frame refresh;
- a request/strobe handshake in one clock domain.

It drives the controller's pixel input and frame-done signal.

## Interface
- `WIDTH`, 128, pixels per line.
- `HEIGHT`, 128, lines per frame.
- `PIXEL_SIZE`, 16, bits per pixel.
- `CHECK_SHIFT`, 4, checker square size is 2^CHECK_SHIFT pixels.
- Derived: `RESOLUTION` = WIDTH*HEIGHT. `AW` = $clog2(RESOLUTION). `WIDTH` must be a multiple of 8.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame from IDLE or DONE.
- `continuous`  in  1  1 = wrap to the next frame automatically; sampled at frame start.
- `mode`  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 framebuffer; sampled at frame start.
- `color`  in  PIXEL_SIZE  solid/checker foreground; sampled at frame start.
- `data_req`  in  1  one-cycle strobe from the controller: current pixel consumed, advance.
- `mem_addr`  out  AW  framebuffer read address, row-major.
- `mem_data`  in  PIXEL_SIZE  framebuffer data, valid 1 clk after `mem_addr`.
- `pixel_out`  out  PIXEL_SIZE  current pixel to the controller.
- `busy`  out  1  high in PREFETCH/STREAM.
- `frame_done`  out  1  level; high in DONE.
- `frame_tick`  out  1  one-cycle pulse on each frame completion.
- `frame_count`  out  8  completed frames, wraps 255→0.
- `overrun`  out  1  sticky; set when `data_req` is dropped.

## Operation
- FSM states: IDLE, PREFETCH, STREAM, DONE.
- IDLE or DONE, on `start`:
  - latch `mode`, `color`, `continuous`;
  - clear x, y, addr and the bar counter;
  - go to PREFETCH; `frame_done` drops.
- PREFETCH: 2 cycles, filling the pipeline for pixel 0. Then go to STREAM with `pixel_out` = pixel(0,0).
- STREAM, on an accepted `data_req`:
  - addr+1; x+1; when x = WIDTH-1, x←0 and y+1;
  - the bar counter advances every WIDTH/8 pixels and resets at line start.
- Last pixel: accepted `data_req` at addr = RESOLUTION-1:
  - `frame_tick` pulses and `frame_count`+1;
  - if latched `continuous`=1: re-latch `mode`, `color`, `continuous`, wrap counters to 0, go to PREFETCH;
  - else go to DONE.
- Pixel functions (RGB565 constants, truncated or zero-extended to PIXEL_SIZE):
  - mode 0: `color`.
  - mode 1: bar 0..7 = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 2: bit0 of ((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)); 0 → `color`, 1 → 0.
  - mode 3: `mem_data`.
- `start` in PREFETCH/STREAM is ignored.
- `data_req` outside STREAM is ignored and does not set `overrun`.
- `mode`/`color` changes mid-frame have no effect until the next frame start.

## Timing
- Reset values:
  - state IDLE;
  - `pixel_out`, `mem_addr`, `frame_count` = 0;
  - `busy`, `frame_done`, `frame_tick`, `overrun` = 0.
- Reset is effective immediately, including mid-frame; state returns to IDLE.
- Accept pipeline for `data_req` sampled at edge k:
  - counters and `mem_addr` update at edge k;
  - `mem_data` is valid after edge k+1;
  - `pixel_out` updates at edge k+2.
- Minimum `data_req` spacing is 3 clk. A `data_req` within 2 clk of the previously accepted one is dropped and sets `overrun`. `overrun` clears only on reset.
- `start` at edge k:
  - `busy`=1 from edge k;
  - `pixel_out` = pixel 0 at edge k+2;
  - STREAM from edge k+2.
- `frame_tick` is high for exactly the cycle after the final accept edge.
- Single-shot: `busy`=0 and `frame_done`=1 on that same edge.
- Continuous: `frame_done` stays 0, and `pixel_out` = next frame pixel 0 two cycles after the final accept.
- `start` and the final `data_req` in the same cycle: `start` is ignored, and the frame completes normally.

## Test plan
- Solid colour:
  - stimulus: WIDTH=16, HEIGHT=4, mode 0, `color`=07FF, `start`, 64 `data_req` spaced 4 clk;
  - required: every `pixel_out` = 07FF; one `frame_tick`; `frame_done`=1; `frame_count`=1; `busy`=0.
- Colour bars:
  - stimulus: mode 1, WIDTH=16;
  - required: line pixels go FFFF,FFFF,FFE0,FFE0,…,0000,0000; repeats identically on each of the 4 lines.
- Checkerboard:
  - stimulus: mode 2, CHECK_SHIFT=1, `color`=F800;
  - required: (0,0)=F800, (2,0)=0000, (0,2)=0000, (2,2)=F800.
- Framebuffer:
  - stimulus: mode 3, memory model returns data = addr+0x100 with 1-clk latency;
  - required: pixel n = 0x100+n for n = 0..63; `mem_addr` ends at 63.
- Continuous and mid-frame changes:
  - stimulus: `continuous`=1, 3 frames, `mode` switched mid-frame 1;
  - required: the switch takes effect at frame 2 pixel 0; `frame_count`=3; `frame_done` never high.
- Overrun and reset mid-frame:
  - stimulus: `data_req` 2 clk apart, then `rst` low mid-frame;
  - required: second request dropped (addr +1 only) and `overrun`=1; after reset all outputs 0 and state IDLE.
